// File: rtl/act_writeback_if.sv
// act_writeback_if
//   Bundles the control, configuration, status and both memory ports of the
//   activation/writeback stage.
//   master : the writeback block (drives status and memory requests)
//   slave  : the surrounding system (drives control/config and read data)
//   Signals:
//     start, num_rows, src_base, dst_base, shift, relu_en  run request/config
//     busy, done                                            run status
//     out_rd_en, out_rd_addr, out_rd_data                   output-memory read port
//     in_wr_en, in_wr_addr, in_wr_data                      input-memory write port
interface act_writeback_if #(
  parameter int WIDTH_HEIGHT = 16
);
  logic                        start;
  logic [7:0]                  num_rows;
  logic [7:0]                  src_base;
  logic [7:0]                  dst_base;
  logic [3:0]                  shift;
  logic                        relu_en;
  logic                        busy;
  logic                        done;
  logic [WIDTH_HEIGHT-1:0]     out_rd_en;
  logic [WIDTH_HEIGHT*8-1:0]   out_rd_addr;
  logic [WIDTH_HEIGHT*16-1:0]  out_rd_data;
  logic [WIDTH_HEIGHT-1:0]     in_wr_en;
  logic [WIDTH_HEIGHT*8-1:0]   in_wr_addr;
  logic [WIDTH_HEIGHT*8-1:0]   in_wr_data;

  modport master (
    input  start, num_rows, src_base, dst_base, shift, relu_en, out_rd_data,
    output busy, done, out_rd_en, out_rd_addr, in_wr_en, in_wr_addr, in_wr_data
  );

  modport slave (
    output start, num_rows, src_base, dst_base, shift, relu_en, out_rd_data,
    input  busy, done, out_rd_en, out_rd_addr, in_wr_en, in_wr_addr, in_wr_data
  );
endinterface

// File: rtl/act_writeback.sv
// act_writeback
//   Streams a run of rows from the output memory, applies optional ReLU, an
//   arithmetic right shift and signed 8-bit saturation per lane, and writes
//   the bytes into the input memory. One row per cycle, no bubbles.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-low reset
//     bus    act_writeback_if.master (control/config, status, both memory ports)
//   Pipeline: read address issued at edge k, read data captured at edge k+1,
//   requantized write registered at edge k+2.
module act_writeback #(
  parameter int WIDTH_HEIGHT = 16
) (
  input  logic             clk,
  input  logic             reset,
  act_writeback_if.master  bus
);

  localparam int W = WIDTH_HEIGHT;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [7:0]       remaining;   // rows still to issue after the current one
  logic [7:0]       rd_addr;
  logic             rd_en;
  logic [3:0]       shift_q;
  logic             relu_q;
  logic             busy_q;
  logic             done_q;

  logic             cap_valid;
  logic [W*16-1:0]  cap_data;
  logic [7:0]       wr_ptr;      // address for the next write
  logic             wr_en;
  logic [7:0]       wr_addr;
  logic [W*8-1:0]   wr_data;
  logic [W*8-1:0]   quant;

  logic             accept;
  assign accept = (state == S_IDLE) && bus.start;

  // ReLU, arithmetic shift (rounds toward -inf), then clamp to int8.
  function automatic logic [7:0] requant(input logic signed [15:0] x,
                                         input logic [3:0]         sh,
                                         input logic               relu);
    logic signed [15:0] y;
    logic signed [15:0] z;
    y = (relu && x[15]) ? 16'sd0 : x;
    z = y >>> sh;
    if (z > 16'sd127)       return 8'h7F;
    else if (z < -16'sd128) return 8'h80;
    else                    return z[7:0];
  endfunction

  // NOTE: combinational blocks assign a default first so no path leaves the
  // output unassigned, which would otherwise infer a latch.
  always_comb begin
    quant = '0;
    for (int i = 0; i < W; i++) begin
      quant[8*i +: 8] = requant(cap_data[16*i +: 16], shift_q, relu_q);
    end
  end

  // Control FSM. done is raised on the edge that leaves DONE, so it is seen
  // in the first IDLE cycle and a new start can be taken on the next edge.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      rd_addr   <= '0;
      rd_en     <= 1'b0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            busy_q  <= 1'b1;
            shift_q <= bus.shift;
            relu_q  <= bus.relu_en;
            if (bus.num_rows != 8'd0) begin
              rd_en     <= 1'b1;
              rd_addr   <= bus.src_base;
              remaining <= bus.num_rows - 8'd1;
              state     <= S_READ;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_READ: begin
          if (remaining == 8'd0) begin
            rd_en <= 1'b0;
            state <= S_DRAIN;
          end else begin
            rd_addr   <= rd_addr + 8'd1;
            remaining <= remaining - 8'd1;
          end
        end
        // The last row sits in the capture stage during this cycle and is
        // written on the edge that leaves DRAIN.
        S_DRAIN: state <= S_DONE;
        S_DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath: capture read data, then register the requantized write.
  // NOTE: the data registers are reset as well, because every output must
  // read 0 during reset and in-flight rows must not survive it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_valid <= 1'b0;
      cap_data  <= '0;
      wr_ptr    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      cap_valid <= rd_en;
      if (rd_en) cap_data <= bus.out_rd_data;
      wr_en <= cap_valid;
      if (cap_valid) begin
        wr_addr <= wr_ptr;
        wr_data <= quant;
      end
      if (accept)         wr_ptr <= bus.dst_base;
      else if (cap_valid) wr_ptr <= wr_ptr + 8'd1;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.out_rd_en   = {W{rd_en}};
  assign bus.out_rd_addr = {W{rd_addr}};
  assign bus.in_wr_en    = {W{wr_en}};
  assign bus.in_wr_addr  = {W{wr_addr}};
  assign bus.in_wr_data  = wr_data;

endmodule

// File: tb/tb_act_writeback.sv
// tb_act_writeback
//   Directed-vector bench with a scoreboard: each run pushes its expected
//   reads, writes and done pulse (with the edge they must occur on) into
//   queues; a negedge monitor pops and compares whenever the DUT asserts
//   out_rd_en, in_wr_en or done.
module tb_act_writeback;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  act_writeback_if #(.WIDTH_HEIGHT(W)) bus ();

  act_writeback #(.WIDTH_HEIGHT(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] addr;
    int         at_edge;
  } rd_exp_t;

  typedef struct {
    logic [7:0]     addr;
    logic [W*8-1:0] data;
    int             at_edge;
  } wr_exp_t;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  int      done_q[$];

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  // Output-memory contents and the hand-computed bytes each row must yield
  // under the configuration its test uses.
  logic [15:0] mem_lane [256][W];
  logic [7:0]  exp_lane [256][W];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Read data for the address presented after edge E, sampled at E+1.
  always_comb begin
    bus.out_rd_data = '0;
    if (bus.out_rd_en[0]) begin
      for (int i = 0; i < W; i++) begin
        bus.out_rd_data[16*i +: 16] = mem_lane[bus.out_rd_addr[7:0]][i];
      end
    end
  end

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at edge %0d", name, act, exp, edge_cnt);
    end
  endtask

  // Monitor / scoreboard.
  rd_exp_t m_rd;
  wr_exp_t m_wr;
  int      m_dn;
  always @(negedge clk) begin
    if (bus.out_rd_en[0]) begin
      check("rd_expected", 256'(rd_q.size() > 0), 256'd1);
      if (rd_q.size() > 0) begin
        m_rd = rd_q.pop_front();
        check("rd_en_lanes", 256'(bus.out_rd_en), 256'({W{1'b1}}));
        check("rd_addr", 256'(bus.out_rd_addr), 256'({W{m_rd.addr}}));
        check("rd_edge", 256'(edge_cnt), 256'(m_rd.at_edge));
      end
    end
    if (bus.in_wr_en[0]) begin
      check("wr_expected", 256'(wr_q.size() > 0), 256'd1);
      if (wr_q.size() > 0) begin
        m_wr = wr_q.pop_front();
        check("wr_en_lanes", 256'(bus.in_wr_en), 256'({W{1'b1}}));
        check("wr_addr", 256'(bus.in_wr_addr), 256'({W{m_wr.addr}}));
        check("wr_data", 256'(bus.in_wr_data), 256'(m_wr.data));
        check("wr_edge", 256'(edge_cnt), 256'(m_wr.at_edge));
      end
    end
    if (bus.done) begin
      check("done_expected", 256'(done_q.size() > 0), 256'd1);
      if (done_q.size() > 0) begin
        m_dn = done_q.pop_front();
        check("done_edge", 256'(edge_cnt), 256'(m_dn));
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},     256'(bus.busy),        256'd0);
    check({tag, "_done"},     256'(bus.done),        256'd0);
    check({tag, "_rd_en"},    256'(bus.out_rd_en),   256'd0);
    check({tag, "_rd_addr"},  256'(bus.out_rd_addr), 256'd0);
    check({tag, "_wr_en"},    256'(bus.in_wr_en),    256'd0);
    check({tag, "_wr_addr"},  256'(bus.in_wr_addr),  256'd0);
    check({tag, "_wr_data"},  256'(bus.in_wr_data),  256'd0);
  endtask

  task automatic set_lane(input logic [7:0] a, input int lane,
                          input logic [15:0] v, input logic [7:0] e);
    mem_lane[a][lane] = v;
    exp_lane[a][lane] = e;
  endtask

  task automatic clear_row(input logic [7:0] a);
    for (int i = 0; i < W; i++) set_lane(a, i, 16'h0000, 8'h00);
  endtask

  // Issue a start at the current negedge and push every expected event.
  task automatic issue(input int n, input logic [7:0] src, input logic [7:0] dst,
                       input logic [3:0] sh, input logic relu, output int s);
    logic [7:0]     a;
    wr_exp_t        w;
    rd_exp_t        r;
    bus.start    = 1'b1;
    bus.num_rows = 8'(n);
    bus.src_base = src;
    bus.dst_base = dst;
    bus.shift    = sh;
    bus.relu_en  = relu;
    s = edge_cnt + 1;
    for (int k = 0; k < n; k++) begin
      a = src + 8'(k);
      r.addr = a;
      r.at_edge = s + k;
      rd_q.push_back(r);
      w.addr = dst + 8'(k);
      for (int i = 0; i < W; i++) w.data[8*i +: 8] = exp_lane[a][i];
      w.at_edge = s + k + 2;
      wr_q.push_back(w);
    end
    done_q.push_back((n > 0) ? s + n + 2 : s + 1);
    @(negedge clk);
    // Config changes while busy must not leak into the run.
    bus.start    = 1'b0;
    bus.num_rows = 8'hAA;
    bus.src_base = ~src;
    bus.dst_base = ~dst;
    bus.shift    = 4'd7;
    bus.relu_en  = ~relu;
    check("busy_after_start", 256'(bus.busy), 256'd1);
  endtask

  // Whole run; must be entered on a negedge and leaves on the negedge where
  // busy has dropped (done visible in that same cycle).
  task automatic run(input int n, input logic [7:0] src, input logic [7:0] dst,
                     input logic [3:0] sh, input logic relu, input logic inject);
    int s;
    int end_edge;
    issue(n, src, dst, sh, relu, s);
    end_edge = (n > 0) ? s + n + 2 : s + 1;
    for (int c = 0; c < 300 && bus.busy; c++) begin
      if (inject && c == 1) begin
        bus.start    = 1'b1;
        bus.num_rows = 8'd2;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("busy_timeout", 256'(bus.busy), 256'd0);
    check("busy_fall_edge", 256'(edge_cnt), 256'(end_edge));
  endtask

  initial begin
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.num_rows = '0;
    bus.src_base = '0;
    bus.dst_base = '0;
    bus.shift    = '0;
    bus.relu_en  = 1'b0;
    for (int a = 0; a < 256; a++) clear_row(8'(a));

    // Vector tables (hand-computed expected bytes).
    // Row 0x10, shift 2, ReLU on.
    set_lane(8'h10, 0, 16'h0300, 8'h7F);   //  768>>2 = 192 -> 127
    set_lane(8'h10, 1, 16'hFF00, 8'h00);   //  negative -> 0
    set_lane(8'h10, 2, 16'h0050, 8'h14);   //   80>>2 = 20
    set_lane(8'h10, 3, 16'h01FC, 8'h7F);   //  508>>2 = 127
    set_lane(8'h10, 4, 16'h8000, 8'h00);   //  most negative -> 0
    set_lane(8'h10, 5, 16'h0007, 8'h01);   //    7>>2 = 1
    // Row 0x30, shift 1, ReLU off.
    set_lane(8'h30, 0, 16'hFF00, 8'h80);   // -256>>1 = -128
    set_lane(8'h30, 1, 16'h8000, 8'h80);   // -16384 -> -128
    set_lane(8'h30, 2, 16'hFFFE, 8'hFF);   //   -2>>1 = -1
    set_lane(8'h30, 3, 16'h0100, 8'h7F);   //  256>>1 = 128 -> 127
    set_lane(8'h30, 4, 16'h00FE, 8'h7F);   //  254>>1 = 127
    set_lane(8'h30, 5, 16'hFF01, 8'h80);   // -255>>1 = -128
    set_lane(8'h30, 6, 16'hFEFF, 8'h80);   // -257>>1 = -129 -> -128
    set_lane(8'h30, 7, 16'h0001, 8'h00);   //    1>>1 = 0
    set_lane(8'h30, 8, 16'hFFFF, 8'hFF);   //   -1>>1 = -1
    // Row 0x40, shift 15, ReLU off.
    set_lane(8'h40, 0, 16'h7FFF, 8'h00);
    set_lane(8'h40, 1, 16'h8000, 8'hFF);
    set_lane(8'h40, 2, 16'hC000, 8'hFF);
    set_lane(8'h40, 3, 16'h4000, 8'h00);
    // Rows FE,FF,00,01, shift 0: small in-range values pass through.
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < W; i++)
        set_lane(8'hFE + 8'(j), i, 16'(j*16 + i), 8'(j*16 + i));
    // Rows 0x50..0x54, shift 0, ReLU on: odd lanes negative -> 0.
    for (int j = 0; j < 5; j++)
      for (int i = 0; i < W; i++)
        if (i % 2 == 1) set_lane(8'h50 + 8'(j), i, 16'hFFF0, 8'h00);
        else            set_lane(8'h50 + 8'(j), i, 16'(j*8 + i), 8'(j*8 + i));
    // Rows 0x60..0x67, shift 0: pass-through.
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < W; i++)
        set_lane(8'h60 + 8'(j), i, 16'(100 - j*4 - i), 8'(100 - j*4 - i));

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("idle");

    run(1, 8'h10, 8'h20, 4'd2, 1'b1, 1'b0);
    run(1, 8'h30, 8'h31, 4'd1, 1'b0, 1'b0);
    run(1, 8'h40, 8'h41, 4'd15, 1'b0, 1'b0);
    run(4, 8'hFE, 8'hFF, 4'd0, 1'b0, 1'b0);
    run(0, 8'h33, 8'h44, 4'd0, 1'b0, 1'b0);
    run(5, 8'h50, 8'h58, 4'd0, 1'b1, 1'b1);

    // Reset during READ of an 8-row run.
    begin
      int s;
      issue(8, 8'h60, 8'h80, 4'd0, 1'b0, s);
      repeat (3) @(negedge clk);
      #3;
      reset = 1'b0;
      #1;
      check_outputs_zero("midrun_reset");
      rd_q.delete();
      wr_q.delete();
      done_q.delete();
      repeat (2) @(negedge clk);
      check_outputs_zero("held_reset");
      reset = 1'b1;
      @(negedge clk);
    end
    run(3, 8'h60, 8'h90, 4'd0, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    check("rd_q_drained", 256'(rd_q.size()), 256'd0);
    check("wr_q_drained", 256'(wr_q.size()), 256'd0);
    check("done_q_drained", 256'(done_q.size()), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/act_writeback.md
# act_writeback

Post-array activation and requantization stage downstream of the systolic-array top level. On a start pulse it streams a run of rows out of the output memory read port (16 lanes × 16-bit accumulations), applies optional ReLU, an arithmetic right shift and signed 8-bit saturation, and writes the results into the input memory write port. This lets a layer's results feed the next matrix multiply without a host round-trip. It runs after `output_done` and before the next `active`.

## Interface
- `WIDTH_HEIGHT`, 16, lane count (array width/height)
- `clk`  in  1  clock, rising edge; one clock for the whole block
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `start`  in  1  request; sampled only in IDLE
- `num_rows`  in  8  rows to process, 0..255; captured at start
- `src_base`  in  8  first output-memory row address; captured at start
- `dst_base`  in  8  first input-memory row address; captured at start
- `shift`  in  4  arithmetic right-shift amount 0..15; captured at start
- `relu_en`  in  1  clamp negatives to 0; captured at start
- `busy`  out  1  high from the accepted start until done
- `done`  out  1  one-cycle pulse when the last row is written
- `out_rd_en`  out  WIDTH_HEIGHT  output-memory read enable, all lanes driven identically
- `out_rd_addr`  out  WIDTH_HEIGHT*8  output-memory read address, same 8-bit value on every lane
- `out_rd_data`  in  WIDTH_HEIGHT*16  output-memory read data; lane i is bits [16i+15:16i]
- `in_wr_en`  out  WIDTH_HEIGHT  input-memory write enable, all lanes identical
- `in_wr_addr`  out  WIDTH_HEIGHT*8  input-memory write address, same value on every lane
- `in_wr_data`  out  WIDTH_HEIGHT*8  requantized data; lane i is bits [8i+7:8i]

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - `start`=1 with `num_rows`>0 captures the config and goes to READ.
  - `start`=1 with `num_rows`=0 goes to DONE directly.
- READ: issues one row read per cycle at `src_base`+k, for k = 0..num_rows-1. After the last issue it goes to DRAIN.
- DRAIN: waits for the final row to be written, then goes to DONE.
- DONE: pulses `done` for one cycle and returns to IDLE.
- `start` is ignored outside IDLE, and captured config is not affected by input changes while busy.
- Per-lane arithmetic, with x the signed 16-bit lane value:
  - If `relu_en` and x<0, then y=0; otherwise y=x.
  - z = y >>> shift (arithmetic shift, truncates toward −inf).
  - Output = z saturated to the signed 8-bit range [−128, 127].
- Address generation: read and write addresses are 8-bit and wrap modulo 256 (for example, base 0xFE with 4 rows gives FE, FF, 00, 01).
- Write k goes to `dst_base`+k and carries row `src_base`+k.
- Reset (`reset`=0) at any time, including mid-run:
  - FSM forced to IDLE; all outputs 0.
  - In-flight rows are discarded and no `done` pulse is produced.

## Timing
- Reset values: `busy`, `done`, `out_rd_en`, `out_rd_addr`, `in_wr_en`, `in_wr_addr`, `in_wr_data` all 0.
- All outputs are registered.
- Output memory has 1-cycle read latency: data for the address presented at edge E is valid on `out_rd_data` after E and is sampled at E+1.
- Start accepted at edge 0 (N = `num_rows` > 0):
  - `busy`=1 and `out_rd_en`=all-ones from edge 0; `out_rd_addr`=`src_base`+k after edge k.
  - `out_rd_en` returns to 0 at edge N.
  - `in_wr_en`=all-ones after edges 2..N+1, carrying row k after edge k+2.
  - `in_wr_en` returns to 0 at edge N+2.
  - `done`=1 for the one cycle after edge N+2; `busy` falls at edge N+2.
- N=0: `done` pulses after edge 1 and `busy` is high for exactly one cycle; no read or write enables are asserted.
- Throughput is one row per cycle with no bubbles. A new start is accepted one cycle after `done`.

## Test plan
- ReLU and shift on a single row:
  - Stimulus: N=1, src_base=0x10, dst_base=0x20, shift=2, relu_en=1; lanes hold 0x0300, 0xFF00, 0x0050, 0x01FC.
  - Required: one write at 0x20 two cycles after the read, with data 0x7F, 0x00, 0x14, 0x7F; `done` at edge 3.
- Negative saturation:
  - Stimulus: relu_en=0, shift=1; lanes hold 0xFF00, 0x8000, 0xFFFE.
  - Required: written data 0x80, 0x80, 0xFF.
- Streaming with wrap-around:
  - Stimulus: N=4, src_base=0xFE, dst_base=0xFF, shift=0.
  - Required: read addresses FE, FF, 00, 01 on 4 consecutive cycles; write addresses FF, 00, 01, 02 on 4 consecutive cycles, starting 2 cycles later; `done` at edge 6.
- Zero rows and busy start:
  - Stimulus: N=0; then a start pulse during a 5-row run.
  - Required: the N=0 run gives only a done pulse after edge 1 with no enables; the mid-run start is ignored; exactly 5 writes and 1 done occur.
- Reset mid-run:
  - Stimulus: assert `reset`=0 asynchronously during READ of an 8-row run.
  - Required: all outputs 0 immediately and no done pulse; the next start runs normally from the row at `src_base`.
